// File: rtl/fpu_seq_pkg.sv
// Shared definitions for the FPU issue sequencer: operation codes,
// sequencer states and exception-flag bit positions.
package fpu_seq_pkg;

  // fpuOp encoding, identical to the one the FPU decodes
  localparam logic [3:0] OP_ADD      = 4'd0;
  localparam logic [3:0] OP_SUB      = 4'd1;
  localparam logic [3:0] OP_MUL      = 4'd2;
  localparam logic [3:0] OP_DIV      = 4'd3;
  localparam logic [3:0] OP_SGNJ     = 4'd4;
  localparam logic [3:0] OP_MINMAX   = 4'd5;
  localparam logic [3:0] OP_SQRT     = 4'd6;
  localparam logic [3:0] OP_CMP      = 4'd7;
  localparam logic [3:0] OP_CVT_W_S  = 4'd8;
  localparam logic [3:0] OP_CVT_S_W  = 4'd9;

  // Sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } seq_state_e;

  // Bit positions inside the 5-bit {NV,DZ,OF,UF,NX} flag vector
  localparam int FF_W  = 5;
  localparam int FF_NV = 4;
  localparam int FF_DZ = 3;
  localparam int FF_OF = 2;
  localparam int FF_UF = 1;
  localparam int FF_NX = 0;

endpackage

// File: rtl/fpu_latency_lut.sv
// Combinational map from fpuOp to execution latency and an illegal-op flag.
// Kept as its own block so the hazard unit can reuse the same table.
module fpu_latency_lut
  import fpu_seq_pkg::*;
#(
  parameter int LAT_ADD  = 7,
  parameter int LAT_MUL  = 5,
  parameter int LAT_DIV  = 6,
  parameter int LAT_SQRT = 16,
  parameter int LAT_CVT  = 6,
  parameter int LAT_CMP  = 1,
  parameter int CNT_W    = 5
) (
  input  logic [3:0]       i_op,
  output logic [CNT_W-1:0] o_lat,
  output logic             o_illegal
);

  // Latency decode; unused codes take a single cycle and are flagged illegal
  always_comb begin
    o_lat     = CNT_W'(1);
    o_illegal = 1'b0;
    case (i_op)
      OP_ADD, OP_SUB:             o_lat = CNT_W'(LAT_ADD);
      OP_MUL:                     o_lat = CNT_W'(LAT_MUL);
      OP_DIV:                     o_lat = CNT_W'(LAT_DIV);
      OP_SQRT:                    o_lat = CNT_W'(LAT_SQRT);
      OP_CVT_W_S, OP_CVT_S_W:     o_lat = CNT_W'(LAT_CVT);
      OP_SGNJ, OP_MINMAX, OP_CMP: o_lat = CNT_W'(LAT_CMP);
      default: begin
        o_lat     = CNT_W'(1);
        o_illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/fpu_issue_sequencer.sv
// Multi-cycle issue sequencer between EX and the FPU. Stalls the pipeline for
// the fixed latency of the issued op, then strobes result_valid for one cycle.
// Optional sticky exception flags are built when FPU_FFLAGS_EN is defined.
//
// Handshake: an op is accepted in IDLE when fpu_sel=1 and flush=0; stall is
// high from that cycle until the cycle before result_valid. result_valid is a
// one-cycle strobe with fpu_result_out valid in the same cycle; there is no
// back-pressure on the result side.
module fpu_issue_sequencer
  import fpu_seq_pkg::*;
#(
  parameter int width    = 32,
  parameter int LAT_ADD  = 7,
  parameter int LAT_MUL  = 5,
  parameter int LAT_DIV  = 6,
  parameter int LAT_SQRT = 16,
  parameter int LAT_CVT  = 6,
  parameter int LAT_CMP  = 1,
  parameter int CNT_W    = 5
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             fpu_sel,
  input  logic [3:0]       fpuOp,
  input  logic             flush,
  input  logic [width-1:0] fpu_result_in,
`ifdef FPU_FFLAGS_EN
  input  logic             nan_in,
  input  logic             dz_in,
  input  logic             of_in,
  input  logic             uf_in,
  input  logic             fflags_clr,
  output logic [FF_W-1:0]  fflags,
`endif
  output logic             stall,
  output logic             result_valid,
  output logic [width-1:0] fpu_result_out,
  output logic             busy
);

  seq_state_e       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_illegal, w_illegal_nxt;
  logic [width-1:0] r_hold;
  logic [CNT_W-1:0] w_lat;
  logic             w_lut_illegal;
  logic             w_issue;
  logic             w_stall;
  logic             w_valid;
  logic [width-1:0] w_result;

  fpu_latency_lut #(
    .LAT_ADD (LAT_ADD),
    .LAT_MUL (LAT_MUL),
    .LAT_DIV (LAT_DIV),
    .LAT_SQRT(LAT_SQRT),
    .LAT_CVT (LAT_CVT),
    .LAT_CMP (LAT_CMP),
    .CNT_W   (CNT_W)
  ) u_lut (
    .i_op     (fpuOp),
    .o_lat    (w_lat),
    .o_illegal(w_lut_illegal)
  );

  assign w_issue  = fpu_sel & ~flush;
  assign w_result = r_illegal ? '0 : fpu_result_in;

  // Next-state, counter and strobe decode
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_illegal_nxt = r_illegal;
    w_stall       = 1'b0;
    w_valid       = 1'b0;
    case (r_state)
      IDLE: begin
        w_stall = w_issue;
        if (w_issue) begin
          w_cnt_nxt     = w_lat - CNT_W'(1);
          w_illegal_nxt = w_lut_illegal;
          w_state_nxt   = (w_lat == CNT_W'(1)) ? DONE : WAIT;
        end
      end
      WAIT: begin
        w_stall = 1'b1;
        if (flush) begin
          w_cnt_nxt   = '0;
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) w_state_nxt = DONE;
        end
      end
      DONE: begin
        // fpu_sel here belongs to the departing instruction, so no re-issue
        w_valid     = ~flush;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State, counter and latched op attributes
  always_ff @(posedge clock) begin
    if (clear) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_illegal <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_illegal <= w_illegal_nxt;
    end
  end

  // Result hold register: captures each delivered result, killed ops leave it alone
  always_ff @(posedge clock) begin
    if (clear) r_hold <= '0;
    else if (w_valid) r_hold <= w_result;
  end

  assign stall          = w_stall;
  assign result_valid   = w_valid;
  assign busy           = (r_state != IDLE);
  assign fpu_result_out = (r_state == DONE) ? w_result : r_hold;

`ifdef FPU_FFLAGS_EN
  logic            r_is_div;
  logic [FF_W-1:0] r_fflags;
  logic [FF_W-1:0] w_flag_set;

  // Divide-by-zero only counts for an actual divide
  always_ff @(posedge clock) begin
    if (clear) r_is_div <= 1'b0;
    else if (r_state == IDLE && w_issue) r_is_div <= (fpuOp == OP_DIV);
  end

  // Flags raised by the op completing this cycle
  always_comb begin
    w_flag_set        = '0;
    w_flag_set[FF_NV] = nan_in;
    w_flag_set[FF_DZ] = dz_in & r_is_div;
    w_flag_set[FF_OF] = of_in;
    w_flag_set[FF_UF] = uf_in;
    w_flag_set[FF_NX] = 1'b0;
  end

  // Sticky accumulation; software clear wins over a same-cycle update
  always_ff @(posedge clock) begin
    if (clear || fflags_clr) r_fflags <= '0;
    else if (w_valid) r_fflags <= r_fflags | w_flag_set;
  end

  assign fflags = r_fflags;
`endif

endmodule

// File: tb/tb_fpu_issue_sequencer.sv
// Directed testbench for fpu_issue_sequencer. Flag tests are compiled in
// when FPU_FFLAGS_EN is defined.
module tb_fpu_issue_sequencer;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        clear;
  logic        fpu_sel;
  logic [3:0]  fpuOp;
  logic        flush;
  logic [31:0] fpu_result_in;
  logic        stall;
  logic        result_valid;
  logic [31:0] fpu_result_out;
  logic        busy;
`ifdef FPU_FFLAGS_EN
  logic        nan_in, dz_in, of_in, uf_in, fflags_clr;
  logic [4:0]  fflags;
  logic        clr_at_done;
`endif

  fpu_issue_sequencer dut (
    .clock         (clock),
    .clear         (clear),
    .fpu_sel       (fpu_sel),
    .fpuOp         (fpuOp),
    .flush         (flush),
    .fpu_result_in (fpu_result_in),
`ifdef FPU_FFLAGS_EN
    .nan_in        (nan_in),
    .dz_in         (dz_in),
    .of_in         (of_in),
    .uf_in         (uf_in),
    .fflags_clr    (fflags_clr),
    .fflags        (fflags),
`endif
    .stall         (stall),
    .result_valid  (result_valid),
    .fpu_result_out(fpu_result_out),
    .busy          (busy)
  );

  int          n_checks = 0;
  int          n_err    = 0;
  logic [31:0] exp_q[$];
  logic [31:0] held;

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      $error("check %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every result strobe must match the oldest expected result
  always @(negedge clock) begin
    if (result_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL sb_unexpected_valid: observed result %h expected no strobe", fpu_result_out);
      end else begin
        chk("sb_result", fpu_result_out, exp_q.pop_front());
      end
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Issue one op with EX holding it through DONE, check per-cycle timing,
  // then spend one idle cycle checking that the result is held.
  task automatic do_op(input logic [3:0] op, input int lat, input logic [31:0] res,
                       input bit illegal);
    logic [31:0] exp;
    exp = illegal ? 32'h0 : res;
    exp_q.push_back(exp);
    for (int c = 0; c <= lat; c++) begin
      fpu_sel       = 1'b1;
      fpuOp         = op;
      fpu_result_in = (c == lat) ? res : $urandom();
`ifdef FPU_FFLAGS_EN
      fflags_clr    = (c == lat) ? clr_at_done : 1'b0;
`endif
      #1;
      chk($sformatf("op%0d_stall_c%0d", op, c), {31'b0, stall}, {31'b0, c < lat});
      chk($sformatf("op%0d_valid_c%0d", op, c), {31'b0, result_valid}, {31'b0, c == lat});
      chk($sformatf("op%0d_busy_c%0d", op, c), {31'b0, busy}, {31'b0, c > 0});
      if (c == lat) chk($sformatf("op%0d_result", op), fpu_result_out, exp);
      tick();
    end
    fpu_sel       = 1'b0;
    fpu_result_in = $urandom();
`ifdef FPU_FFLAGS_EN
    fflags_clr    = 1'b0;
`endif
    #1;
    chk($sformatf("op%0d_idle_busy", op), {31'b0, busy}, 32'h0);
    chk($sformatf("op%0d_idle_stall", op), {31'b0, stall}, 32'h0);
    chk($sformatf("op%0d_held", op), fpu_result_out, exp);
    held = exp;
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int ops[6];
    int lats[6];
    ops  = '{0, 1, 8, 9, 4, 5};
    lats = '{7, 7, 6, 6, 1, 1};
    clear = 1'b1; fpu_sel = 1'b0; fpuOp = 4'd0; flush = 1'b0; fpu_result_in = 32'h0;
`ifdef FPU_FFLAGS_EN
    nan_in = 1'b0; dz_in = 1'b0; of_in = 1'b0; uf_in = 1'b0; fflags_clr = 1'b0;
    clr_at_done = 1'b0;
`endif
    tick(); tick();
    chk("rst_stall", {31'b0, stall}, 32'h0);
    chk("rst_valid", {31'b0, result_valid}, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_result", fpu_result_out, 32'h0);
`ifdef FPU_FFLAGS_EN
    chk("rst_fflags", {27'b0, fflags}, 32'h0);
`endif
    clear = 1'b0;
    tick();

    // mul, sqrt, illegal, cmp
    do_op(4'd2, 5, 32'h40C00000, 1'b0);
    do_op(4'd6, 16, 32'h3FB504F3, 1'b0);
    do_op(4'd12, 1, 32'hDEADBEEF, 1'b1);
    do_op(4'd7, 1, 32'h3F800000, 1'b0);

    // remaining legal ops
    for (int i = 0; i < 6; i++) do_op(4'(ops[i]), lats[i], $urandom(), 1'b0);

`ifdef FPU_FFLAGS_EN
    dz_in = 1'b1;
    do_op(4'd3, 6, 32'h7F800000, 1'b0);
    chk("ff_div_dz", {27'b0, fflags}, 32'h08);
    dz_in = 1'b0; nan_in = 1'b1; clr_at_done = 1'b1;
    do_op(4'd0, 7, 32'h7FC00000, 1'b0);
    chk("ff_clr_priority", {27'b0, fflags}, 32'h00);
    nan_in = 1'b0; clr_at_done = 1'b0; dz_in = 1'b1;
    do_op(4'd0, 7, 32'h12345678, 1'b0);
    chk("ff_dz_not_div", {27'b0, fflags}, 32'h00);
    dz_in = 1'b0; of_in = 1'b1; uf_in = 1'b1;
    do_op(4'd2, 5, 32'h7F7FFFFF, 1'b0);
    chk("ff_of_uf", {27'b0, fflags}, 32'h06);
    of_in = 1'b0; uf_in = 1'b0; nan_in = 1'b1;
    do_op(4'd7, 1, 32'h0, 1'b0);
    chk("ff_nv_sticky", {27'b0, fflags}, 32'h16);
    nan_in = 1'b0; dz_in = 1'b1;
    do_op(4'd3, 6, 32'hFF800000, 1'b0);
    chk("ff_all", {27'b0, fflags}, 32'h1E);
    dz_in = 1'b0; nan_in = 1'b1;
`endif

    // flush an add in cycle 3
    for (int c = 0; c <= 3; c++) begin
      fpu_sel = 1'b1; fpuOp = 4'd0; flush = (c == 3); fpu_result_in = $urandom();
      #1;
      chk($sformatf("flush_stall_c%0d", c), {31'b0, stall}, 32'h1);
      tick();
    end
    fpu_sel = 1'b0; flush = 1'b0;
    #1;
    chk("flush_stall_c4", {31'b0, stall}, 32'h0);
    chk("flush_busy_c4", {31'b0, busy}, 32'h0);
    chk("flush_held", fpu_result_out, held);
    for (int c = 0; c < 8; c++) tick();
`ifdef FPU_FFLAGS_EN
    chk("flush_fflags", {27'b0, fflags}, 32'h1E);
`endif

    // flush landing in DONE of a cmp
    fpu_sel = 1'b1; fpuOp = 4'd7; fpu_result_in = 32'h0BAD0BAD;
    #1;
    chk("flushdone_stall_c0", {31'b0, stall}, 32'h1);
    tick();
    flush = 1'b1;
    #1;
    chk("flushdone_valid_c1", {31'b0, result_valid}, 32'h0);
    chk("flushdone_busy_c1", {31'b0, busy}, 32'h1);
    tick();
    fpu_sel = 1'b0;
    #1;
    chk("flushidle_stall", {31'b0, stall}, 32'h0);
    tick();
    flush = 1'b0;
    #1;
    chk("flushdone_busy_after", {31'b0, busy}, 32'h0);
    chk("flushdone_held", fpu_result_out, held);
`ifdef FPU_FFLAGS_EN
    chk("flushdone_fflags", {27'b0, fflags}, 32'h1E);
    nan_in = 1'b0;
`endif
    tick();

    // two back-to-back divs, fpu_sel held through the first DONE
    exp_q.push_back(32'h3F000000);
    exp_q.push_back(32'h3E800000);
    for (int c = 0; c <= 13; c++) begin
      fpu_sel = 1'b1; fpuOp = 4'd3;
      fpu_result_in = (c == 6) ? 32'h3F000000 : (c == 13) ? 32'h3E800000 : $urandom();
      #1;
      chk($sformatf("div2_valid_c%0d", c), {31'b0, result_valid}, {31'b0, (c == 6) || (c == 13)});
      chk($sformatf("div2_stall_c%0d", c), {31'b0, stall},
          {31'b0, (c < 6) || ((c >= 7) && (c < 13))});
      chk($sformatf("div2_busy_c%0d", c), {31'b0, busy}, {31'b0, (c != 0) && (c != 7)});
      tick();
    end
    fpu_sel = 1'b0;
    #1;
    chk("div2_held", fpu_result_out, 32'h3E800000);
    tick();

    // clear in cycle 8 of a sqrt
    for (int c = 0; c <= 8; c++) begin
      fpu_sel = 1'b1; fpuOp = 4'd6; clear = (c == 8); fpu_result_in = $urandom();
      #1;
      chk($sformatf("clr_stall_c%0d", c), {31'b0, stall}, 32'h1);
      tick();
    end
    fpu_sel = 1'b0; clear = 1'b0;
    #1;
    chk("clr_stall_c9", {31'b0, stall}, 32'h0);
    chk("clr_busy_c9", {31'b0, busy}, 32'h0);
    chk("clr_result_c9", fpu_result_out, 32'h0);
`ifdef FPU_FFLAGS_EN
    chk("clr_fflags", {27'b0, fflags}, 32'h0);
`endif
    for (int c = 0; c < 12; c++) tick();
    chk("sb_drained", exp_q.size(), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
